// File: rtl/lsu_riscv_if.sv
// Core-side and memory-side signals of the load/store unit.
// master is the LSU's view; slave is the surrounding core plus data memory.
interface lsu_riscv_if;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        core_misaligned_o;
   logic        core_fault_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   modport master (
      input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
             mem_rd_i, mem_ready_i,
      output core_rd_o, core_stall_o, core_misaligned_o, core_fault_o,
             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
   );

   modport slave (
      output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
             mem_rd_i, mem_ready_i,
      input  core_rd_o, core_stall_o, core_misaligned_o, core_fault_o,
             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
   );
endinterface

// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: stalls the core for one word-addressed memory access,
// generates byte enables / replicated store data, and extends load data for writeback.
module lsu_riscv #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   lsu_riscv_if.master bus
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam bit TIMEOUT_EN = (TIMEOUT > 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic is_misaligned(input logic we, input logic [2:0] size,
                                          input logic [1:0] o);
      case (size)
         3'd0:    is_misaligned = we & 1'b0;
         3'd4:    is_misaligned = we;
         3'd1:    is_misaligned = o[0];
         3'd5:    is_misaligned = we | o[0];
         3'd2:    is_misaligned = |o;
         default: is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] o);
      case (size)
         3'd0, 3'd4: byte_en = 4'b0001 << o;
         3'd1, 3'd5: byte_en = 4'b0011 << o;
         3'd2:       byte_en = 4'b1111;
         default:    byte_en = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_rep(input logic [2:0] size, input logic [31:0] wd);
      case (size)
         3'd0:    store_rep = {4{wd[7:0]}};
         3'd1:    store_rep = {2{wd[15:0]}};
         default: store_rep = wd;
      endcase
   endfunction

   // Lane select by shifting the word down, then sign or zero extend.
   function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] o,
                                            input logic [31:0] word);
      logic [31:0]        byte_sh;
      logic [31:0]        half_sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] b_s;
      logic signed [31:0] h_s;
      byte_sh = word >> {o, 3'b000};
      half_sh = word >> {o[1], 4'b0000};
      b       = signed'(byte_sh[7:0]);
      h       = signed'(half_sh[15:0]);
      b_s     = 32'(b);
      h_s     = 32'(h);
      case (size)
         3'd0:    load_ext = b_s;
         3'd1:    load_ext = h_s;
         3'd4:    load_ext = {24'd0, byte_sh[7:0]};
         3'd5:    load_ext = {16'd0, half_sh[15:0]};
         default: load_ext = word;
      endcase
   endfunction

   logic misaligned;
   assign misaligned = is_misaligned(bus.core_we_i, bus.core_size_i, bus.core_addr_i[1:0]);

   always_comb begin
      state_d               = state_q;
      cnt_d                 = cnt_q;
      bus.core_rd_o         = '0;
      bus.core_stall_o      = 1'b0;
      bus.core_misaligned_o = 1'b0;
      bus.core_fault_o      = 1'b0;
      bus.mem_req_o         = 1'b0;
      bus.mem_we_o          = 1'b0;
      bus.mem_be_o          = byte_en(bus.core_size_i, bus.core_addr_i[1:0]);
      bus.mem_addr_o        = bus.core_addr_i;
      bus.mem_wd_o          = store_rep(bus.core_size_i, bus.core_wd_i);

      case (state_q)
         IDLE: begin
            if (bus.core_req_i) begin
               if (misaligned) begin
                  bus.core_misaligned_o = 1'b1;
               end else begin
                  bus.mem_req_o    = 1'b1;
                  bus.mem_we_o     = bus.core_we_i;
                  bus.core_stall_o = 1'b1;
                  state_d          = BUSY;
                  cnt_d            = '0;
               end
            end
         end
         BUSY: begin
            bus.mem_req_o = 1'b1;
            bus.mem_we_o  = bus.core_we_i;
            if (bus.mem_ready_i) begin
               state_d = IDLE;
               if (!bus.core_we_i) begin
                  bus.core_rd_o = load_ext(bus.core_size_i, bus.core_addr_i[1:0], bus.mem_rd_i);
               end
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               bus.core_fault_o = 1'b1;
               bus.mem_req_o    = 1'b0;
               bus.mem_we_o     = 1'b0;
               state_d          = IDLE;
            end else begin
               bus.core_stall_o = 1'b1;
               cnt_d            = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset silences every output, including an in-flight access.
      if (rst_i) begin
         bus.core_rd_o         = '0;
         bus.core_stall_o      = 1'b0;
         bus.core_misaligned_o = 1'b0;
         bus.core_fault_o      = 1'b0;
         bus.mem_req_o         = 1'b0;
         bus.mem_we_o          = 1'b0;
         bus.mem_be_o          = '0;
         bus.mem_addr_o        = '0;
         bus.mem_wd_o          = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lsu_riscv.sv
// Randomized scoreboard bench for lsu_riscv: the driver pushes the expected outcome of
// each access, an independent negedge monitor pops and compares what the DUT presents.
module tb_lsu_riscv;

   localparam int T = 4;

   logic clk_i = 1'b0;
   logic rst_i;

   lsu_riscv_if bus();

   lsu_riscv #(.TIMEOUT(T)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          mis;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          fault;
      int          stall;
      bit          abandon;
   } exp_t;

   exp_t sb[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   bit   in_txn    = 1'b0;
   int   stall_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   task automatic pop_exp(output exp_t e, output bit ok);
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard_underflow: DUT responded with no access outstanding at %0t", $time);
         ok = 1'b0;
      end else begin
         e  = sb.pop_front();
         ok = 1'b1;
      end
   endtask

   // ---------------- reference model (plain arithmetic on the access rules) ----------------
   function automatic bit model_mis(input bit we, input logic [2:0] sz, input logic [31:0] a);
      int unsigned s;
      int unsigned o;
      s = 32'(sz);
      o = a % 4;
      if (s == 3 || s == 6 || s == 7) return 1'b1;
      if (we && (s == 4 || s == 5)) return 1'b1;
      if ((s == 1 || s == 5) && (o % 2) != 0) return 1'b1;
      if (s == 2 && o != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
      int unsigned o;
      int unsigned v;
      o = a % 4;
      if (sz == 0 || sz == 4) v = 1 << o;
      else if (sz == 1 || sz == 5) v = 3 << o;
      else if (sz == 2) v = 15;
      else v = 0;
      return 4'(v);
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] sz, input logic [31:0] w);
      if (sz == 0) return (w % 256) * 32'h0101_0101;
      if (sz == 1) return (w % 65536) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] model_rd(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] w);
      int unsigned o;
      longint      v;
      o = a % 4;
      if (sz == 0 || sz == 4) begin
         v = longint'((w >> (8 * o)) % 256);
         if (sz == 0 && v >= 128) v = v - 256;
      end else if (sz == 1 || sz == 5) begin
         v = longint'((w >> (16 * (o / 2))) % 65536);
         if (sz == 1 && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(w);
      end
      return v[31:0];
   endfunction

   // ---------------- driver ----------------
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         bus.core_req_i  = 1'b0;
         bus.core_we_i   = 1'($urandom_range(0, 1));
         bus.core_size_i = 3'($urandom_range(0, 7));
         bus.core_addr_i = $urandom;
         bus.core_wd_i   = $urandom;
         bus.mem_rd_i    = $urandom;
         bus.mem_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk_i); #1;
      end
   endtask

   // d = number of BUSY cycles with mem_ready_i low before it rises (d >= T never rises).
   task automatic run_txn(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int d,
                          input bit abandon);
      exp_t e;
      int   n_busy;
      e.mis     = model_mis(we, sz, addr);
      e.we      = we;
      e.be      = model_be(sz, addr);
      e.addr    = addr;
      e.wd      = model_wd(sz, wd);
      e.fault   = !e.mis && (d >= T);
      e.stall   = e.mis ? 0 : ((d < T) ? d + 1 : T);
      e.rd      = (!e.mis && !we && d < T) ? model_rd(sz, addr, rdata) : 32'd0;
      e.abandon = abandon;
      sb.push_back(e);

      bus.core_req_i  = 1'b1;
      bus.core_we_i   = we;
      bus.core_size_i = sz;
      bus.core_addr_i = addr;
      bus.core_wd_i   = wd;
      bus.mem_rd_i    = $urandom;
      bus.mem_ready_i = 1'($urandom_range(0, 1));
      if (e.mis) begin
         @(posedge clk_i); #1;
      end else begin
         n_busy = (d < T) ? d + 1 : T;
         for (int k = 0; k < n_busy; k++) begin
            @(posedge clk_i); #1;
            bus.mem_ready_i = (k == d);
            bus.mem_rd_i    = rdata;
            if (abandon && k == 1) begin
               rst_i = 1'b1;
               @(posedge clk_i); #1;
               rst_i           = 1'b0;
               bus.core_req_i  = 1'b0;
               bus.mem_ready_i = 1'b0;
               return;
            end
         end
         @(posedge clk_i); #1;
      end
      bus.core_req_i  = 1'b0;
      bus.mem_ready_i = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk_i) begin
      exp_t e;
      bit   ok;
      if (rst_i) begin
         chk("reset_outputs_zero",
             {|bus.core_rd_o, bus.core_stall_o, bus.core_misaligned_o, bus.core_fault_o,
              bus.mem_req_o, bus.mem_we_o, |bus.mem_be_o, |bus.mem_addr_o, |bus.mem_wd_o}, 0);
         if (in_txn) begin
            pop_exp(e, ok);
            if (ok) chk("abandoned_by_reset", e.abandon, 1);
            in_txn = 1'b0;
         end
      end else begin
         chk("mis_fault_exclusive", bus.core_misaligned_o & bus.core_fault_o, 0);
         if (!in_txn) begin
            if (bus.core_misaligned_o) begin
               pop_exp(e, ok);
               if (ok) begin
                  chk("misaligned", bus.core_misaligned_o, e.mis);
                  chk("misaligned_req_stall", {bus.mem_req_o, bus.core_stall_o}, 0);
               end
            end else if (bus.mem_req_o) begin
               if (sb.size() == 0) begin
                  pop_exp(e, ok);
               end else begin
                  e = sb[0];
                  chk("misaligned", bus.core_misaligned_o, e.mis);
                  chk("mem_we", bus.mem_we_o, e.we);
                  chk("mem_be", bus.mem_be_o, e.be);
                  chk("mem_addr", bus.mem_addr_o, e.addr);
                  if (e.we) chk("mem_wd", bus.mem_wd_o, e.wd);
                  in_txn    = 1'b1;
                  stall_cnt = 0;
               end
            end else begin
               chk("idle_quiet", {bus.core_stall_o, bus.core_fault_o, |bus.core_rd_o}, 0);
            end
         end
         if (in_txn) begin
            if (bus.core_stall_o) begin
               stall_cnt++;
               chk("busy_outputs", {bus.mem_req_o, bus.core_fault_o, |bus.core_rd_o}, 3'b100);
            end else begin
               pop_exp(e, ok);
               if (ok) begin
                  chk("fault", bus.core_fault_o, e.fault);
                  chk("stall_cycles", stall_cnt, e.stall);
                  chk("mem_req_at_end", bus.mem_req_o, !e.fault);
                  chk("load_data", bus.core_rd_o, e.rd);
               end
               in_txn = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_i           = 1'b1;
      bus.core_req_i  = 1'b1;
      bus.core_we_i   = 1'b0;
      bus.core_size_i = 3'd2;
      bus.core_addr_i = 32'h0000_0100;
      bus.core_wd_i   = 32'hFFFF_FFFF;
      bus.mem_rd_i    = 32'hFFFF_FFFF;
      bus.mem_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i          = 1'b0;
      bus.core_req_i = 1'b0;
      idle(2);

      run_txn(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      run_txn(1'b0, 3'd0, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 0, 1'b0);
      run_txn(1'b0, 3'd4, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 0, 1'b0);
      run_txn(1'b0, 3'd1, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 0, 1'b0);
      run_txn(1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 0, 1'b0);
      idle(1);
      run_txn(1'b1, 3'd1, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 3, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b0);
      run_txn(1'b1, 3'd1, 32'h0000_0003, 32'h5555_6666, 32'h0, 0, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h1111_2222, 100, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'h5A5A_A5A5, 1, 1'b0);
      idle(1);
      run_txn(1'b0, 3'd2, 32'h0000_0080, 32'h0, 32'h0, 100, 1'b1);
      run_txn(1'b0, 3'd0, 32'h0000_0081, 32'h0, 32'h0000_FF00, 0, 1'b0);
      idle(2);

      for (int i = 0; i < 250; i++) begin
         logic [2:0]  sz;
         logic [31:0] a;
         bit          we;
         case ($urandom_range(0, 13))
            0, 1:    sz = 3'd0;
            2, 3:    sz = 3'd1;
            4, 5, 6: sz = 3'd2;
            7, 8:    sz = 3'd4;
            9, 10:   sz = 3'd5;
            11:      sz = 3'd3;
            12:      sz = 3'd6;
            default: sz = 3'd7;
         endcase
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 3'd2) ? 2'b00 : {a[1], 1'b0};
         we = 1'($urandom_range(0, 1));
         run_txn(we, sz, a, $urandom, $urandom, int'($urandom_range(0, 4)), 1'b0);
         idle(int'($urandom_range(0, 2)));
      end

      idle(4);
      chk("scoreboard_drained", sb.size(), 0);
      chk("no_open_access", in_txn, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
